digseg_scanner: RTL and testbench
=================================

Name: digseg_scanner

Overview:
- Time-multiplexes a bank of hex digits onto one shared 7-segment decoder.
- Holds a double-buffered display word, steps one digit at a time through a refresh schedule, and outputs the active digit's 4-bit nibble plus a one-hot digit enable.
- The nibble feeds the per-digit hex-to-segment decoder directly downstream; the digit enable drives the display's common lines.

Parameters:
- NUM_DIGITS, 8: number of hex digits scanned. Legal range 2..16.
- CLK_DIV, 50000: clk cycles each digit is lit (SHOW phase). Must be ≥1.
- GAP_CYCLES, 2: clk cycles of all-off ghosting guard after each digit. 0 means no GAP phase.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_in, input, 4*NUM_DIGITS: new display value; digit i is data_in[4i+3:4i], and digit 0 is the least significant.
- load, input, 1: single-cycle strobe that captures data_in.
- lz_suppress, input, 1: when 1, leading-zero digits are blanked.
- nibble, output, 4: hex value of the current digit, sent to the downstream decoder.
- digit_sel, output, NUM_DIGITS: one-hot, active-high enable of the lit digit; all zero when nothing is lit.
- frame_done, output, 1: one-cycle pulse each time the scan wraps to digit 0.

Behaviour:
- Registers:
  - shadow (4*NUM_DIGITS bits)
  - pending flag
  - disp (4*NUM_DIGITS bits)
  - idx (clog2 NUM_DIGITS bits)
  - div_cnt, wide enough for max(CLK_DIV, GAP_CYCLES)
  - state, one of {SHOW, GAP}
  - frame_done register
- Reset (rst_n low, asynchronous): shadow=0, disp=0, pending=0, idx=0, div_cnt=0, state=SHOW, frame_done=0. Result after reset: nibble=0, digit_sel=1 (digit 0 lit), frame_done=0.
- Outputs are combinational from registers only, with no input-to-output path:
  - nibble = disp[4*idx+3:4*idx].
  - digit_sel = (state==SHOW && !blank(idx)) ? (1<<idx) : 0.
- blank(i) is 1 iff all of the following hold:
  - lz_suppress=1
  - i≠0
  - disp digits i..NUM_DIGITS-1 are all zero
  - Digit 0 is never blanked. lz_suppress is sampled live, with no latching.
- SHOW phase:
  - div_cnt counts 0..CLK_DIV-1.
  - On the cycle div_cnt==CLK_DIV-1: div_cnt→0. If GAP_CYCLES>0, state→GAP; otherwise advance.
- GAP phase:
  - digit_sel=0 and nibble is held.
  - div_cnt counts 0..GAP_CYCLES-1.
  - On the last count: div_cnt→0, state→SHOW, advance.
- Advance:
  - idx→idx+1, or 0 if idx==NUM_DIGITS-1 (this is the wrap).
  - Each digit period is CLK_DIV+GAP_CYCLES cycles; a frame is NUM_DIGITS × that.
- On a wrap:
  - frame_done=1 for exactly one cycle: the first cycle with idx=0.
  - If pending=1: disp←shadow, pending←0.
- load=1 without a wrap: shadow←data_in, pending←1. A later load before the wrap overwrites shadow, so only the last value is shown.
- load=1 on the same cycle as a wrap: disp←data_in directly (bypassing shadow), shadow←data_in, pending←0.
- disp changes only at frame boundaries, so a frame never shows a mix of two values.
- Reset asserted mid-frame: everything returns to reset values immediately, and any pending load is discarded.
- Wrap arithmetic: idx never reaches NUM_DIGITS, including for non-power-of-two NUM_DIGITS.

Test Plan (NUM_DIGITS=4, CLK_DIV=3, GAP_CYCLES=1 unless stated):
1. Reset, release, no load → digit_sel pattern over 16 cycles: 0001 ×3, 0000 ×1, 0010 ×3, 0000, 0100 ×3, 0000, 1000 ×3, 0000. nibble=0 throughout. frame_done pulses at cycle 16 only.
2. load with data_in=16'hA5C3 mid-frame → nibble stays 0 until the wrap. Next frame shows nibble 3, C, 5, A while digit_sel is 0001, 0010, 0100, 1000 respectively.
3. load 16'h1234, then 16'h5678 within the same frame → the next frame shows 8, 7, 6, 5. The value 1234 never appears.
4. load 16'h00F0 on exactly the wrap cycle → the frame starting that cycle already shows 0, F, 0, 0. pending=0 afterwards.
5. disp=16'h0007 with lz_suppress=1 → digit_sel is 0001 in the digit-0 slot and 0000 in the digit-1..3 slots. disp=0 → digit 0 is still lit with nibble 0. Toggling lz_suppress to 0 → all four digits are lit.
6. Assert rst_n low mid-GAP with a pending load → outputs immediately return to nibble=0, digit_sel=0001, frame_done=0. The pending value never displays. Repeat with GAP_CYCLES=0: there are no all-zero digit_sel cycles.

Source files
------------

// File: rtl/digseg_scanner_if.sv
// Display-side signal bundle for the digit scanner: new display word and controls
// in, active digit nibble, one-hot common-line enable and frame pulse out.
interface digseg_scanner_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic                    load;
    logic                    lz_suppress;
    logic [3:0]              nibble;
    logic [NUM_DIGITS-1:0]   digit_sel;
    logic                    frame_done;

    modport master (
        output data_in, load, lz_suppress,
        input  nibble, digit_sel, frame_done
    );

    modport slave (
        input  data_in, load, lz_suppress,
        output nibble, digit_sel, frame_done
    );
endinterface

// File: rtl/digseg_scanner.sv
// Time-multiplexed hex digit scanner: double-buffered display word, SHOW/GAP refresh
// schedule per digit, optional leading-zero blanking, frame-boundary-only updates.
module digseg_scanner #(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 50000,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    digseg_scanner_if.slave  bus
);
    localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
    localparam int IW      = $clog2(NUM_DIGITS);
    localparam int DW      = 4 * NUM_DIGITS;

    localparam logic [CW-1:0] SHOW_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_SHOW = 1'b0,
        ST_GAP  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [DW-1:0]    shadow_reg, disp_reg;
    logic             pending_reg;
    logic             frame_done_reg;
    logic             advance;
    logic             wrap;

    logic [3:0]             digit_w [NUM_DIGITS];
    logic [NUM_DIGITS-1:1]  tail_zero;
    logic [NUM_DIGITS-1:0]  blank_vec;

    // tail_zero[i]: digits i..NUM_DIGITS-1 are all zero; digit 0 is never blanked.
    assign blank_vec[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_w[gi] = disp_reg[4*gi +: 4];
        end
        for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
            if (gi == NUM_DIGITS - 1) begin : g_top
                assign tail_zero[gi] = (digit_w[gi] == 4'd0);
            end else begin : g_mid
                assign tail_zero[gi] = (digit_w[gi] == 4'd0) && tail_zero[gi+1];
            end
            assign blank_vec[gi] = bus.lz_suppress & tail_zero[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CW'(1);
        idx_next   = idx_reg;
        advance    = 1'b0;
        case (state_reg)
            ST_SHOW: begin
                if (cnt_reg == SHOW_LAST) begin
                    cnt_next = '0;
                    if (GAP_CYCLES > 0) begin
                        state_next = ST_GAP;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_reg == GAP_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_SHOW;
                    advance    = 1'b1;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = ST_SHOW;
            end
        endcase
        if (advance) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IW'(1);
        end
        wrap = advance && (idx_reg == IDX_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_SHOW;
            cnt_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            idx_reg   <= idx_next;
        end
    end

    // A load coinciding with the wrap goes straight to disp so the new frame shows it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg     <= '0;
            disp_reg       <= '0;
            pending_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= wrap;
            if (wrap) begin
                if (bus.load) begin
                    disp_reg    <= bus.data_in;
                    shadow_reg  <= bus.data_in;
                    pending_reg <= 1'b0;
                end else if (pending_reg) begin
                    disp_reg    <= shadow_reg;
                    pending_reg <= 1'b0;
                end
            end else if (bus.load) begin
                shadow_reg  <= bus.data_in;
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.nibble     = digit_w[idx_reg];
    assign bus.digit_sel  = (state_reg == ST_SHOW && !blank_vec[idx_reg])
                            ? (NUM_DIGITS'(1) << idx_reg) : '0;
    assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_digseg_scanner.sv
// Directed bench for digseg_scanner: 4 digits, 3-cycle SHOW, 1-cycle GAP, plus a
// second instance without GAP for the reset/no-gap scenario.
module tb_digseg_scanner;
    localparam int N   = 4;
    localparam int DIV = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    digseg_scanner_if #(.NUM_DIGITS(N)) bus0 ();
    digseg_scanner_if #(.NUM_DIGITS(N)) bus1 ();

    digseg_scanner #(.NUM_DIGITS(N), .CLK_DIV(DIV), .GAP_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    digseg_scanner #(.NUM_DIGITS(N), .CLK_DIV(DIV), .GAP_CYCLES(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic skip(input int n);
        repeat (n) cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus0.load = 1'b0; bus0.data_in = '0; bus0.lz_suppress = 1'b0;
        bus1.load = 1'b0; bus1.data_in = '0; bus1.lz_suppress = 1'b0;
        skip(3);
        vectors++;
        if (bus0.nibble !== 4'h0) begin
            miscompares++; $display("FAIL reset_nibble: got %h want 0", bus0.nibble);
        end
        vectors++;
        if (bus0.digit_sel !== 4'b0001) begin
            miscompares++; $display("FAIL reset_sel: got %b want 0001", bus0.digit_sel);
        end
        vectors++;
        if (bus0.frame_done !== 1'b0) begin
            miscompares++; $display("FAIL reset_fd: got %b want 0", bus0.frame_done);
        end
        vectors++;
        if (bus1.digit_sel !== 4'b0001) begin
            miscompares++; $display("FAIL reset_sel_nogap: got %b want 0001", bus1.digit_sel);
        end
        rst_n = 1'b1;
        $display("reset: nibble=%h sel=%b fd=%b", bus0.nibble, bus0.digit_sel, bus0.frame_done);
    endtask

    // Starts at frame position 0 right after reset release; ends at position 0 of frame 2.
    task automatic test_scan_idle();
        logic [3:0] exp_sel;
        for (int c = 0; c < 16; c++) begin
            exp_sel = (c % 4 < 3) ? (4'b0001 << (c / 4)) : 4'b0000;
            vectors++;
            if (bus0.digit_sel !== exp_sel || bus0.nibble !== 4'h0 || bus0.frame_done !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_c%0d: got sel=%b nib=%h fd=%b want sel=%b nib=0 fd=0",
                         c, bus0.digit_sel, bus0.nibble, bus0.frame_done, exp_sel);
            end
            cycle();
        end
        vectors++;
        if (bus0.frame_done !== 1'b1 || bus0.digit_sel !== 4'b0001) begin
            miscompares++;
            $display("FAIL idle_wrap: got fd=%b sel=%b want fd=1 sel=0001", bus0.frame_done, bus0.digit_sel);
        end
        $display("scan_idle: frame complete, fd=%b", bus0.frame_done);
    endtask

    task automatic test_load_midframe();
        logic [15:0] val = 16'hA5C3;
        logic [3:0]  exp_sel;
        skip(5);
        bus0.load = 1'b1; bus0.data_in = val;
        cycle();
        bus0.load = 1'b0;
        for (int c = 6; c < 16; c++) begin
            vectors++;
            if (bus0.nibble !== 4'h0) begin
                miscompares++; $display("FAIL midload_hold_c%0d: got %h want 0", c, bus0.nibble);
            end
            cycle();
        end
        for (int c = 0; c < 16; c++) begin
            exp_sel = (c % 4 < 3) ? (4'b0001 << (c / 4)) : 4'b0000;
            vectors++;
            if (bus0.nibble !== val[4*(c/4) +: 4] || bus0.digit_sel !== exp_sel ||
                bus0.frame_done !== (c == 0)) begin
                miscompares++;
                $display("FAIL midload_c%0d: got nib=%h sel=%b fd=%b want nib=%h sel=%b fd=%b",
                         c, bus0.nibble, bus0.digit_sel, bus0.frame_done,
                         val[4*(c/4) +: 4], exp_sel, (c == 0));
            end
            cycle();
        end
        $display("load_midframe: data=%h shown next frame", val);
    endtask

    task automatic test_overwrite();
        logic [15:0] old_val = 16'hA5C3;
        logic [15:0] val = 16'h5678;
        logic [3:0]  exp_sel;
        skip(2);
        bus0.load = 1'b1; bus0.data_in = 16'h1234;
        cycle();
        bus0.load = 1'b0;
        skip(4);
        bus0.load = 1'b1; bus0.data_in = val;
        cycle();
        bus0.load = 1'b0;
        for (int c = 8; c < 16; c++) begin
            vectors++;
            if (bus0.nibble !== old_val[4*(c/4) +: 4]) begin
                miscompares++;
                $display("FAIL overwrite_hold_c%0d: got %h want %h", c, bus0.nibble, old_val[4*(c/4) +: 4]);
            end
            cycle();
        end
        for (int c = 0; c < 16; c++) begin
            exp_sel = (c % 4 < 3) ? (4'b0001 << (c / 4)) : 4'b0000;
            vectors++;
            if (bus0.nibble !== val[4*(c/4) +: 4] || bus0.digit_sel !== exp_sel) begin
                miscompares++;
                $display("FAIL overwrite_c%0d: got nib=%h sel=%b want nib=%h sel=%b",
                         c, bus0.nibble, bus0.digit_sel, val[4*(c/4) +: 4], exp_sel);
            end
            cycle();
        end
        $display("overwrite: 1234 then %h, frame shows %h", val, val);
    endtask

    task automatic test_wrap_load();
        logic [15:0] val = 16'h00F0;
        logic [3:0]  exp_sel;
        skip(15);
        bus0.load = 1'b1; bus0.data_in = val;
        cycle();
        bus0.load = 1'b0;
        for (int c = 0; c < 16; c++) begin
            exp_sel = (c % 4 < 3) ? (4'b0001 << (c / 4)) : 4'b0000;
            vectors++;
            if (bus0.nibble !== val[4*(c/4) +: 4] || bus0.digit_sel !== exp_sel ||
                bus0.frame_done !== (c == 0)) begin
                miscompares++;
                $display("FAIL wrapload_c%0d: got nib=%h sel=%b fd=%b want nib=%h sel=%b fd=%b",
                         c, bus0.nibble, bus0.digit_sel, bus0.frame_done,
                         val[4*(c/4) +: 4], exp_sel, (c == 0));
            end
            cycle();
        end
        $display("wrap_load: %h shown in the frame starting at the wrap", val);
    endtask

    task automatic test_lz();
        logic [15:0] vals  [4] = '{16'h00F0, 16'h0007, 16'h0000, 16'h0000};
        logic [3:0]  masks [4] = '{4'b0011, 4'b0001, 4'b0001, 4'b1111};
        logic        lzs   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] val;
        logic [3:0]  exp_sel;
        for (int k = 0; k < 4; k++) begin
            val = vals[k];
            if (k > 0) begin
                skip(15);
                bus0.load = 1'b1; bus0.data_in = val;
                cycle();
                bus0.load = 1'b0;
            end
            bus0.lz_suppress = lzs[k];
            #1;
            for (int c = 0; c < 16; c++) begin
                exp_sel = (c % 4 < 3) ? ((4'b0001 << (c / 4)) & masks[k]) : 4'b0000;
                vectors++;
                if (bus0.nibble !== val[4*(c/4) +: 4] || bus0.digit_sel !== exp_sel) begin
                    miscompares++;
                    $display("FAIL lz%0d_c%0d: got nib=%h sel=%b want nib=%h sel=%b",
                             k, c, bus0.nibble, bus0.digit_sel, val[4*(c/4) +: 4], exp_sel);
                end
                cycle();
            end
            $display("lz: disp=%h lz=%b lit mask=%b", val, lzs[k], masks[k]);
        end
        bus0.lz_suppress = 1'b0;
    endtask

    task automatic test_reset_midgap();
        logic [3:0] exp_sel;
        skip(15);
        bus0.load = 1'b1; bus0.data_in = 16'h9999;
        cycle();
        bus0.load = 1'b0;
        skip(1);
        bus0.load = 1'b1; bus0.data_in = 16'hBEEF;
        cycle();
        bus0.load = 1'b0;
        cycle();
        vectors++;
        if (bus0.digit_sel !== 4'b0000 || bus0.nibble !== 4'h9) begin
            miscompares++;
            $display("FAIL pre_reset_gap: got sel=%b nib=%h want sel=0000 nib=9", bus0.digit_sel, bus0.nibble);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus0.nibble !== 4'h0 || bus0.digit_sel !== 4'b0001 || bus0.frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got nib=%h sel=%b fd=%b want nib=0 sel=0001 fd=0",
                     bus0.nibble, bus0.digit_sel, bus0.frame_done);
        end
        skip(2);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if (bus0.nibble !== 4'h0 || bus0.frame_done !== (c == 16)) begin
                miscompares++;
                $display("FAIL discard_c%0d: got nib=%h fd=%b want nib=0 fd=%b",
                         c, bus0.nibble, bus0.frame_done, (c == 16));
            end
            exp_sel = 4'b0001 << ((c % 12) / 3);
            vectors++;
            if (bus1.digit_sel !== exp_sel || bus1.frame_done !== (c == 12)) begin
                miscompares++;
                $display("FAIL nogap_c%0d: got sel=%b fd=%b want sel=%b fd=%b",
                         c, bus1.digit_sel, bus1.frame_done, exp_sel, (c == 12));
            end
            cycle();
        end
        $display("reset_midgap: pending BEEF discarded, no-gap scan continuous");
    endtask

    initial begin
        test_reset();
        test_scan_idle();
        test_load_midframe();
        test_overwrite();
        test_wrap_load();
        test_lz();
        test_reset_midgap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
